// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - write/read handshake and status bundle for router_fifo
interface router_fifo_if;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_en;
  logic       full;
  logic       empty;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, data_out_en, full, empty
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, data_out_en, full, empty
  );
endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - 16x9 packet FIFO with header-driven byte counter and tri-stated read port
module router_fifo (
  input  logic          clock,
  input  logic          resetn,
  input  logic          soft_reset,
  router_fifo_if.slave  bus
);

  logic [8:0] mem_q [16];
  logic [8:0] mem_d [16];
  logic [4:0] wr_ptr_q, wr_ptr_d;
  logic [4:0] rd_ptr_q, rd_ptr_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       do_wr, do_rd;
  logic [8:0] rd_entry;
  logic [7:0] data_out_w;

  // Status flags come straight from the pointers; bit 4 tells full from empty.
  assign bus.empty = (wr_ptr_q == rd_ptr_q);
  assign bus.full  = (wr_ptr_q[3:0] == rd_ptr_q[3:0]) && (wr_ptr_q[4] != rd_ptr_q[4]);

  // Read port floats whenever the output enable has been dropped.
  assign data_out_w      = oe_q ? dout_q : 8'hzz;
  assign bus.data_out    = data_out_w;
  assign bus.data_out_en = oe_q;

  // Next-state: push/pop qualified by pre-edge flags, counter tracks bytes left in packet.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    do_wr    = bus.write_enb && !bus.full;
    do_rd    = bus.read_enb && !bus.empty;
    rd_entry = mem_q[rd_ptr_q[3:0]];
    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      oe_d     = 1'b0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q[3:0]] = {bus.lfd_state, bus.data_in};
        wr_ptr_d             = wr_ptr_q + 5'd1;
      end
      if (do_rd) begin
        dout_d   = rd_entry[7:0];
        oe_d     = 1'b1;
        rd_ptr_d = rd_ptr_q + 5'd1;
        if (rd_entry[8]) begin
          // Header carries payload length in [7:2]; +1 accounts for the parity byte.
          cnt_d = rd_entry[7:2] + 6'd1;
        end else if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end
      end else if (cnt_q == 6'd0) begin
        oe_d = 1'b0;
      end
    end
  end

  // State registers; async reset clears storage and drives data_out low (not floating).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= 8'h00;
      oe_q     <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
    end
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL use a single clock and asynchronous active-low reset: clock input 1 (rising-edge clock); resetn input 1 (asynchronous, active-low reset).
REQ-002 Port soft_reset SHALL be input 1: synchronous flush, driven by the synchronizer's soft_reset_x for this port.
REQ-003 Port write_enb SHALL be input 1: push request, driven by one bit of the synchronizer's write_enb[2:0].
REQ-004 Port read_enb SHALL be input 1: pop request from the downstream reader.
REQ-005 Port lfd_state SHALL be input 1: marks the current write as a packet header byte.
REQ-006 Port data_in SHALL be input 8: write data.
REQ-007 Port data_out SHALL be output 8: read data, registered, tri-stated when idle.
REQ-008 Port full SHALL be output 1: storage holds 16 entries.
REQ-009 Port empty SHALL be output 1: storage holds 0 entries.

Function
REQ-010 Storage SHALL be 16 entries x 9 bits; bit 8 = header marker, bits 7:0 = data.
REQ-011 Write and read pointers SHALL be 5 bits each; bits 3:0 address storage; bit 4 is the wrap flag.
REQ-012 empty SHALL be combinational, 1 when the pointers are equal.
REQ-013 full SHALL be combinational, 1 when bits 3:0 are equal and bit 4 differs.
REQ-014 Write: at a rising edge with write_enb=1 and full=0, entry[wr_ptr[3:0]] SHALL receive {lfd_state, data_in}, then wr_ptr increments modulo 32.
REQ-015 Read: at a rising edge with read_enb=1 and empty=0, data_out SHALL receive entry[rd_ptr[3:0]][7:0], then rd_ptr increments modulo 32; read latency is 1 cycle.
REQ-016 A write while full, or a read while empty, SHALL be ignored, leaving pointers and storage unchanged.
REQ-017 A simultaneous read and write SHALL both execute when permitted, evaluated against the pre-edge full/empty (at full: the read proceeds and the write is dropped; at empty: the write proceeds and the read is dropped).
REQ-018 A 6-bit packet counter SHALL load entry[7:2]+1 (payload length plus parity byte) when the entry being read has bit 8 = 1.
REQ-019 On a read of a non-header entry, the counter SHALL decrement if nonzero and hold at 0 otherwise.
REQ-020 On any rising edge with no read executed and counter = 0, data_out SHALL go to 8'hZZ; otherwise it holds its last value.
REQ-021 soft_reset=1 at a rising edge SHALL set both pointers to 0, counter to 0 and data_out to 8'hZZ, and SHALL take priority over a same-cycle read or write; storage contents are don't-care.
REQ-022 Pointer wrap from 31 to 0 SHALL need no special handling and SHALL preserve FIFO order across wrap.

Reset
REQ-023 resetn=0 SHALL immediately (without a clock edge) set wr_ptr=0, rd_ptr=0, counter=0, data_out=8'h00, and all 16 storage entries to 9'h000.
REQ-024 During reset, outputs SHALL be empty=1 and full=0.
REQ-025 The block SHALL ignore all other inputs while resetn=0 and resume operation at the first rising edge after deassertion.
REQ-026 Reset asserted mid-packet SHALL discard all stored data and in-progress counter state.

Verification
REQ-027 Reset: with resetn=0 -> empty=1, full=0, data_out=8'h00; pulse write_enb while reset is held -> empty remains 1.
REQ-028 Packet: write header 8'h0D with lfd_state=1, then bytes 8'hA1, 8'hA2, 8'hA3 and parity 8'h5C with lfd_state=0; read 5 consecutive cycles -> data_out shows 0D, A1, A2, A3, 5C one cycle after each read edge, counter goes 4, 3, 2, 1, 0, empty=1, next idle edge gives data_out=8'hZZ.
REQ-029 Full and wrap: write 16 bytes 8'h00..8'h0F -> full=1 after the 16th; a 17th write of 8'hFF is dropped; read 16 -> 00..0F in order; repeat twice more to cross pointer wrap with identical results.
REQ-030 Simultaneous: at full, assert read_enb and write_enb together -> one entry is read, the write is dropped, full=0 afterwards; at empty, assert both -> write only, then empty=0.
REQ-031 soft_reset mid-packet: after 3 of 5 bytes are written and 1 is read, assert soft_reset for one cycle -> empty=1, full=0, data_out=8'hZZ, and the concurrent write is ignored.
REQ-032 Async reset mid-read: drop resetn between clock edges -> data_out=8'h00 and empty=1 without waiting for an edge.
